// File: rtl/mont_exp_ctrl_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package mont_exp_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 256;
    localparam int unsigned EXP_W_DEF  = 32;
    localparam int unsigned CNT_W      = 8;

    // Sequencer states; W_* states wait for the multiplier's done pulse.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SCAN     = 4'd1,
        ST_CONV_IN  = 4'd2,
        ST_W_CIN    = 4'd3,
        ST_SQR      = 4'd4,
        ST_W_SQR    = 4'd5,
        ST_MUL      = 4'd6,
        ST_W_MUL    = 4'd7,
        ST_CONV_OUT = 4'd8,
        ST_W_COUT   = 4'd9,
        ST_DONE     = 4'd10
    } state_e;

    // Tag of the multiplication currently issued, for debug visibility.
    typedef enum logic [1:0] {
        OP_CIN  = 2'd0,
        OP_SQR  = 2'd1,
        OP_MUL  = 2'd2,
        OP_COUT = 2'd3
    } mm_op_e;

    // Operation counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Start/done handshake bus between the sequencer and a Montgomery multiplier core.
interface mont_exp_ctrl_if #(
    parameter int unsigned DATA_W = 256
);
    logic                       mm_start;
    logic [DATA_W-1:0]          mm_a;
    logic [DATA_W-1:0]          mm_b;
    mont_exp_ctrl_pkg::mm_op_e  mm_op;
    logic                       mm_done;
    logic [DATA_W-1:0]          mm_res;

    modport master (
        output mm_start, mm_a, mm_b, mm_op,
        input  mm_done, mm_res
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_op,
        output mm_done, mm_res
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned EXP_W   = EXP_W_DEF,
    parameter bit          SKIP_LZ = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [EXP_W-1:0]  exp,
    input  logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] one_m,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  mm_cnt,
    mont_exp_ctrl_if.master   mm
);

    localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_e            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_base, w_base;
    logic [DATA_W-1:0] r_r2, w_r2;
    logic [DATA_W-1:0] r_acc, w_acc;
    logic [DATA_W-1:0] r_base_m, w_base_m;
    logic [DATA_W-1:0] r_result, w_result;
    logic [DATA_W-1:0] r_mm_a, w_mm_a;
    logic [DATA_W-1:0] r_mm_b, w_mm_b;
    logic [EXP_W-1:0]  r_exp, w_exp;
    logic [IDX_W-1:0]  r_idx, w_idx;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    mm_op_e            r_mm_op, w_mm_op;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_mm_start, w_mm_start;
    logic              w_cur_bit;
    logic              w_idx_zero;
    logic              w_exp_zero;

    assign w_cur_bit  = r_exp[r_idx];
    assign w_idx_zero = (r_idx == '0);
    assign w_exp_zero = (r_exp == '0);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the NEXT decision is folded into the W_SQR/W_MUL exits.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:     if (start) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (!SKIP_LZ)                    w_state_nxt = ST_CONV_IN;
                else if (w_exp_zero)             w_state_nxt = ST_CONV_OUT;
                else if (w_cur_bit || w_idx_zero) w_state_nxt = ST_CONV_IN;
            end
            ST_CONV_IN:  w_state_nxt = ST_W_CIN;
            ST_W_CIN:    if (mm.mm_done) w_state_nxt = ST_SQR;
            ST_SQR:      w_state_nxt = ST_W_SQR;
            ST_W_SQR: begin
                if (mm.mm_done) begin
                    if (w_cur_bit)       w_state_nxt = ST_MUL;
                    else if (w_idx_zero) w_state_nxt = ST_CONV_OUT;
                    else                 w_state_nxt = ST_SQR;
                end
            end
            ST_MUL:      w_state_nxt = ST_W_MUL;
            ST_W_MUL: begin
                if (mm.mm_done) w_state_nxt = w_idx_zero ? ST_CONV_OUT : ST_SQR;
            end
            ST_CONV_OUT: w_state_nxt = ST_W_COUT;
            ST_W_COUT:   if (mm.mm_done) w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output next values; mm_start is a one-cycle pulse per issue state.
    always_comb begin
        w_base     = r_base;
        w_r2       = r_r2;
        w_acc      = r_acc;
        w_base_m   = r_base_m;
        w_result   = r_result;
        w_mm_a     = r_mm_a;
        w_mm_b     = r_mm_b;
        w_exp      = r_exp;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_mm_op    = r_mm_op;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_mm_start = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_base = base;
                    w_exp  = exp;
                    w_r2   = r2;
                    w_acc  = one_m;
                    w_idx  = IDX_W'(EXP_W - 1);
                    w_cnt  = '0;
                    w_busy = 1'b1;
                end
            end
            ST_SCAN: begin
                if (SKIP_LZ && !w_cur_bit && !w_idx_zero) w_idx = r_idx - IDX_W'(1);
            end
            ST_CONV_IN: begin
                w_mm_start = 1'b1;
                w_mm_a     = r_base;
                w_mm_b     = r_r2;
                w_mm_op    = OP_CIN;
                w_cnt      = sat_inc(r_cnt);
            end
            ST_W_CIN: begin
                if (mm.mm_done) w_base_m = mm.mm_res;
            end
            ST_SQR: begin
                w_mm_start = 1'b1;
                w_mm_a     = r_acc;
                w_mm_b     = r_acc;
                w_mm_op    = OP_SQR;
                w_cnt      = sat_inc(r_cnt);
            end
            ST_W_SQR: begin
                if (mm.mm_done) begin
                    w_acc = mm.mm_res;
                    if (!w_cur_bit && !w_idx_zero) w_idx = r_idx - IDX_W'(1);
                end
            end
            ST_MUL: begin
                w_mm_start = 1'b1;
                w_mm_a     = r_acc;
                w_mm_b     = r_base_m;
                w_mm_op    = OP_MUL;
                w_cnt      = sat_inc(r_cnt);
            end
            ST_W_MUL: begin
                if (mm.mm_done) begin
                    w_acc = mm.mm_res;
                    if (!w_idx_zero) w_idx = r_idx - IDX_W'(1);
                end
            end
            ST_CONV_OUT: begin
                w_mm_start = 1'b1;
                w_mm_a     = r_acc;
                w_mm_b     = DATA_W'(1);
                w_mm_op    = OP_COUT;
                w_cnt      = sat_inc(r_cnt);
            end
            ST_W_COUT: begin
                if (mm.mm_done) begin
                    w_result = mm.mm_res;
                    w_done   = 1'b1;
                    w_busy   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base     <= '0;
            r_r2       <= '0;
            r_acc      <= '0;
            r_base_m   <= '0;
            r_result   <= '0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_exp      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_mm_op    <= OP_CIN;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mm_start <= 1'b0;
        end else begin
            r_base     <= w_base;
            r_r2       <= w_r2;
            r_acc      <= w_acc;
            r_base_m   <= w_base_m;
            r_result   <= w_result;
            r_mm_a     <= w_mm_a;
            r_mm_b     <= w_mm_b;
            r_exp      <= w_exp;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_mm_op    <= w_mm_op;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_mm_start <= w_mm_start;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign mm_cnt      = r_cnt;
    assign mm.mm_start = r_mm_start;
    assign mm.mm_a     = r_mm_a;
    assign mm.mm_b     = r_mm_b;
    assign mm.mm_op    = r_mm_op;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench: two sequencers (leading-zero skip on/off) each paired with a stalling MM core model.
module tb_mont_exp_ctrl;
    import mont_exp_ctrl_pkg::*;

    localparam int unsigned DW = 256;
    localparam int unsigned EW = 32;
    localparam int          NI = 2;

    typedef struct packed {
        logic [63:0] res;
        logic [7:0]  cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [DW-1:0] base;
    logic [EW-1:0] exp_v;
    logic [DW-1:0] r2;
    logic [DW-1:0] one_m;

    logic          busy_w   [NI];
    logic          done_w   [NI];
    logic [DW-1:0] result_w [NI];
    logic [7:0]    cnt_w    [NI];
    logic          in_mul   [NI];

    exp_t          sb_q [NI][$];
    longint unsigned n_mod = 11;
    int            inject_req = 0;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic record_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [63:0] fold64(input logic [DW-1:0] v);
        return (v[DW-1:64] != '0) ? '1 : v[63:0];
    endfunction

    // Plain right-to-left modular exponentiation.
    function automatic logic [63:0] model_pow(input longint unsigned b, input longint unsigned e,
                                              input longint unsigned n);
        longint unsigned r = 1 % n;
        longint unsigned x = b % n;
        while (e != 0) begin
            if ((e & 1) != 0) r = (r * x) % n;
            x = (x * x) % n;
            e = e >> 1;
        end
        return r;
    endfunction

    // Multiplications: conversion in + one squaring per scanned bit + one multiply per set bit + conversion out.
    function automatic logic [7:0] model_cnt(input longint unsigned e, input bit skip);
        int bits = 0;
        int ones = 0;
        for (int i = 0; i < int'(EW); i++) begin
            if (((e >> i) & 1) != 0) begin
                bits = i + 1;
                ones++;
            end
        end
        if (!skip) return 8'(2 + int'(EW) + ones);
        if (e == 0) return 8'd1;
        return 8'(2 + bits + ones);
    endfunction

    // a*b*2^-DW mod n via bit-serial reduction, fully reduced.
    function automatic logic [63:0] mont_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] n);
        logic [127:0] t;
        t = 128'(a) * 128'(b);
        for (int i = 0; i < int'(DW); i++) begin
            if (t[0]) t = t + 128'(n);
            t = t >> 1;
        end
        if (t >= 128'(n)) t = t - 128'(n);
        return 64'(t);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        mont_exp_ctrl_if #(.DATA_W(DW)) u_if ();

        mont_exp_ctrl #(.DATA_W(DW), .EXP_W(EW), .SKIP_LZ(g == 0)) u_dut (
            .clk    (clk),
            .rstn   (rstn),
            .start  (start),
            .base   (base),
            .exp    (exp_v),
            .r2     (r2),
            .one_m  (one_m),
            .busy   (busy_w[g]),
            .done   (done_w[g]),
            .result (result_w[g]),
            .mm_cnt (cnt_w[g]),
            .mm     (u_if)
        );

        assign in_mul[g] = u_if.mm_start && (u_if.mm_op == OP_MUL);

        // Multiplier core model: random stall, operand stability checks, occasional stray done pulses.
        initial begin : core
            int            stall = -1;
            int            inj_seen = 0;
            bit            spur = 1'b0;
            bit            rst_hit = 1'b0;
            logic [DW-1:0] a_cap, b_cap;
            logic [63:0]   res_cap;
            u_if.mm_done = 1'b0;
            u_if.mm_res  = '0;
            forever begin
                @(negedge clk);
                u_if.mm_done = 1'b0;
                if (!rstn) rst_hit = 1'b1;
                if (spur) begin
                    u_if.mm_done = 1'b1;
                    u_if.mm_res  = DW'($urandom);
                    spur = 1'b0;
                end else if (inject_req != inj_seen) begin
                    inj_seen     = inject_req;
                    u_if.mm_done = 1'b1;
                    u_if.mm_res  = DW'($urandom);
                end
                if (stall > 0) begin
                    if (!rst_hit) begin
                        check("mm_operands_stable",
                              {63'd0, (u_if.mm_a == a_cap) && (u_if.mm_b == b_cap)}, 64'd1);
                        check("mm_start_single_pulse", {63'd0, u_if.mm_start}, 64'd0);
                    end
                    stall--;
                end else if (stall == 0) begin
                    u_if.mm_done = 1'b1;
                    u_if.mm_res  = DW'(res_cap);
                    stall = -1;
                    spur  = ($urandom_range(0, 3) == 0);
                end else if (rstn && u_if.mm_start) begin
                    a_cap   = u_if.mm_a;
                    b_cap   = u_if.mm_b;
                    res_cap = mont_mul(a_cap[63:0], b_cap[63:0], n_mod);
                    stall   = $urandom_range(1, 50);
                    rst_hit = 1'b0;
                end
            end
        end

        // Monitor: reset values, completion against the scoreboard, result hold while idle.
        initial begin : mon
            logic          prev_done = 1'b0;
            logic [DW-1:0] last_res  = '0;
            exp_t          e;
            forever begin
                @(negedge clk);
                if (!rstn) begin
                    check("reset_outputs",
                          {56'd0, busy_w[g], done_w[g], u_if.mm_start, (u_if.mm_a != '0),
                           (u_if.mm_b != '0), (result_w[g] != '0), (cnt_w[g] != '0), 1'b0},
                          64'd0);
                    last_res = '0;
                end else if (done_w[g]) begin
                    check("done_single_cycle", {63'd0, prev_done}, 64'd0);
                    check("busy_low_at_done", {63'd0, busy_w[g]}, 64'd0);
                    if (sb_q[g].size() == 0) begin
                        record_fail("unexpected_done");
                    end else begin
                        e = sb_q[g].pop_front();
                        check("result", fold64(result_w[g]), e.res);
                        check("mm_cnt", {56'd0, cnt_w[g]}, {56'd0, e.cnt});
                    end
                    last_res = result_w[g];
                end else if (!busy_w[g]) begin
                    check("result_held", fold64(result_w[g]), fold64(last_res));
                end
                prev_done = done_w[g];
            end
        end
    end

    // Load operands, queue expectations and pulse start; operands are scrambled once accepted.
    task automatic issue_job(input longint unsigned n, input longint unsigned b,
                             input longint unsigned e);
        longint unsigned rm = 1;
        for (int i = 0; i < int'(DW); i++) rm = (rm << 1) % n;
        n_mod = n;
        base  = DW'(b);
        exp_v = EW'(e);
        one_m = DW'(rm);
        r2    = DW'((rm * rm) % n);
        for (int i = 0; i < NI; i++)
            sb_q[i].push_back('{res: model_pow(b, e, n), cnt: model_cnt(e, i == 0)});
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        base  = DW'($urandom);
        exp_v = EW'($urandom);
        one_m = DW'($urandom);
        r2    = DW'($urandom);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check("busy_after_start", {63'd0, busy_w[i]}, 64'd1);
    endtask

    task automatic wait_jobs(input bit spam);
        int cyc = 0;
        while ((busy_w[0] || busy_w[1]) && cyc < 5000) begin
            if (spam && busy_w[0] && busy_w[1] && ($urandom_range(0, 7) == 0)) begin
                start = 1'b1;
                base  = DW'($urandom);
                exp_v = EW'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (busy_w[0] || busy_w[1]) begin
            record_fail("job_timeout");
            @(posedge clk); #1 rstn = 1'b0;
            @(posedge clk); #1 rstn = 1'b1;
            for (int i = 0; i < NI; i++) sb_q[i].delete();
            repeat (60) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_job(input longint unsigned n, input longint unsigned b,
                           input longint unsigned e, input bit spam);
        issue_job(n, b, e);
        wait_jobs(spam);
    endtask

    // Assert reset while the skip-enabled instance waits on its first MUL.
    task automatic abort_in_mul(input longint unsigned n, input longint unsigned b,
                                input longint unsigned e);
        int cyc = 0;
        issue_job(n, b, e);
        while (!in_mul[0] && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_mul[0]) record_fail("reach_w_mul_timeout");
        @(posedge clk); #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) sb_q[i].delete();
        @(posedge clk); #1 rstn = 1'b1;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        longint unsigned rn, rb, re;
        rstn  = 1'b1;
        start = 1'b0;
        base  = '0;
        exp_v = '0;
        r2    = '0;
        one_m = '0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_job(11, 5, 3, 1'b0);
        run_job(11, 7, 0, 1'b0);
        run_job(13, 2, 64'h8000_0000, 1'b1);
        run_job(13, 12, 64'hFFFF_FFFF, 1'b1);
        run_job(11, 0, 5, 1'b0);
        inject_req++;
        repeat (4) @(negedge clk);

        abort_in_mul(13, 6, 64'h0000_00B3);
        run_job(11, 5, 3, 1'b0);

        for (int j = 0; j < 10; j++) begin
            rn = longint'($urandom_range(3, 32'h7FFF_FFFF)) | 1;
            rb = longint'($urandom) % rn;
            re = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom >> $urandom_range(0, 31));
            run_job(rn, rb, re, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                inject_req++;
                repeat (3) @(negedge clk);
            end
        end

        for (int i = 0; i < NI; i++) check("scoreboard_drained", 64'(sb_q[i].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
